mp64_mmio_ctrl: RTL and testbench

//   MMIO peripheral sequencer between the bus arbiter's MMIO port and the peripheral slots:

---
 rtl/mp64_mmio_ctrl_pkg.sv | 33 +++
 rtl/mp64_mmio_wdog.sv | 27 ++
 rtl/mp64_mmio_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mp64_mmio_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp64_mmio_ctrl_pkg.sv
// Shared definitions for the MP64 MMIO sequencer: slot map, error causes,
// FSM state encodings and the default access timeout.
package mp64_mmio_ctrl_pkg;

    // Peripheral slot indices (slot = up_addr[11:8])
    localparam int unsigned MMIO_SLOT_UART  = 0;
    localparam int unsigned MMIO_SLOT_TIMER = 1;
    localparam int unsigned MMIO_SLOT_DISK  = 2;
    localparam int unsigned MMIO_SLOT_NIC   = 3;
    localparam int unsigned MMIO_SLOT_MBOX  = 4;
    localparam int unsigned MMIO_SLOT_SPIN  = 5;

    // Error cause codes recorded by the optional error log
    localparam logic [1:0] MMIO_ERR_NONE       = 2'd0;
    localparam logic [1:0] MMIO_ERR_UNMAPPED   = 2'd1;
    localparam logic [1:0] MMIO_ERR_TIMEOUT    = 2'd2;
    localparam logic [1:0] MMIO_ERR_TIMEOUT_WR = 2'd3;

    typedef enum logic [1:0] {
        MMIO_ST_IDLE   = 2'd0,
        MMIO_ST_ACCESS = 2'd1,
        MMIO_ST_RESP   = 2'd2,
        MMIO_ST_GAP    = 2'd3
    } mmio_state_e;

    localparam int unsigned MMIO_TIMEOUT = 255;

    // Saturating 8-bit increment for the error counter
    function automatic logic [7:0] mmio_sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mp64_mmio_wdog.sv
// Loadable down-counter used as the per-access timeout watchdog.
// expired is high while enabled and the count has reached zero.
module mp64_mmio_wdog (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] load_val,
    output logic        expired
);

    logic [15:0] count_q;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != 16'd0)) begin
            count_q <= count_q - 16'd1;
        end
    end

    assign expired = en && (count_q == 16'd0);

endmodule

// File: rtl/mp64_mmio_ctrl.sv
// MMIO sequencer: decodes the 12-bit MMIO offset to a peripheral slot, runs a
// req/ack handshake with a timeout watchdog, and returns an error response for
// unmapped or hung accesses.
// Optional build macro MP64_MMIO_ERRLOG_EN adds the err_log_* ports.
module mp64_mmio_ctrl
    import mp64_mmio_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PERIPH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = MMIO_TIMEOUT,
    parameter logic [63:0] ERR_RDATA      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_req,
    input  logic [11:0]              up_addr,
    input  logic [63:0]              up_wdata,
    input  logic                     up_wen,
    input  logic [1:0]               up_size,
    output logic [63:0]              up_rdata,
    output logic                     up_ack,
    output logic                     up_err,
    output logic [NUM_PERIPH-1:0]    p_req,
    output logic [7:0]               p_addr,
    output logic [63:0]              p_wdata,
    output logic                     p_wen,
    output logic [1:0]               p_size,
    input  logic [NUM_PERIPH*64-1:0] p_rdata,
    input  logic [NUM_PERIPH-1:0]    p_ack,
    output logic                     err_irq,
    input  logic                     err_clr
`ifdef MP64_MMIO_ERRLOG_EN
    ,
    output logic [11:0]              err_log_addr,
    output logic [1:0]               err_log_cause,
    output logic [7:0]               err_log_cnt
`endif
);

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);

    mmio_state_e           state;
    logic                  mapped;
    logic                  accept;
    logic                  ack_hit;
    logic                  expired;
    logic                  timeout_hit;
    logic [NUM_PERIPH-1:0] sel_onehot;
    logic [63:0]           sel_rdata;

    assign mapped      = ({1'b0, up_addr[11:8]} < 5'(NUM_PERIPH));
    assign accept      = (state == MMIO_ST_IDLE) && up_req;
    // p_req is one-hot on the selected slot during ACCESS, so it masks stray acks
    assign ack_hit     = (state == MMIO_ST_ACCESS) && |(p_ack & p_req);
    assign timeout_hit = (state == MMIO_ST_ACCESS) && !ack_hit && expired;

    // Slot decode of the incoming offset and read-data select of the active slot
    always_comb begin
        sel_onehot = '0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            sel_onehot[i] = (up_addr[11:8] == 4'(i));
            sel_rdata     = sel_rdata | (p_rdata[i*64 +: 64] & {64{p_req[i]}});
        end
    end

    mp64_mmio_wdog u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && mapped),
        .en       (state == MMIO_ST_ACCESS),
        .load_val (TIMEOUT_LOAD),
        .expired  (expired)
    );

    // Sequencer FSM with registered handshake, bus and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MMIO_ST_IDLE;
            p_req    <= '0;
            p_addr   <= '0;
            p_wdata  <= '0;
            p_wen    <= 1'b0;
            p_size   <= '0;
            up_rdata <= '0;
            up_ack   <= 1'b0;
            up_err   <= 1'b0;
            err_irq  <= 1'b0;
        end else begin
            // A new error outranks a simultaneous clear
            if ((state == MMIO_ST_RESP) && up_err) begin
                err_irq <= 1'b1;
            end else if (err_clr) begin
                err_irq <= 1'b0;
            end

            case (state)
                MMIO_ST_IDLE: begin
                    if (up_req) begin
                        if (mapped) begin
                            p_req   <= sel_onehot;
                            p_addr  <= up_addr[7:0];
                            p_wdata <= up_wdata;
                            p_wen   <= up_wen;
                            p_size  <= up_size;
                            state   <= MMIO_ST_ACCESS;
                        end else begin
                            // Unmapped: answer directly, no slot is touched
                            up_rdata <= ERR_RDATA;
                            up_ack   <= 1'b1;
                            up_err   <= 1'b1;
                            state    <= MMIO_ST_RESP;
                        end
                    end
                end
                MMIO_ST_ACCESS: begin
                    if (ack_hit) begin
                        up_rdata <= sel_rdata;
                        up_ack   <= 1'b1;
                        up_err   <= 1'b0;
                        p_req    <= '0;
                        state    <= MMIO_ST_RESP;
                    end else if (expired) begin
                        up_rdata <= ERR_RDATA;
                        up_ack   <= 1'b1;
                        up_err   <= 1'b1;
                        p_req    <= '0;
                        state    <= MMIO_ST_RESP;
                    end
                end
                MMIO_ST_RESP: begin
                    up_ack <= 1'b0;
                    up_err <= 1'b0;
                    state  <= MMIO_ST_GAP;
                end
                MMIO_ST_GAP: begin
                    state <= MMIO_ST_IDLE;
                end
                default: begin
                    state <= MMIO_ST_IDLE;
                end
            endcase
        end
    end

`ifdef MP64_MMIO_ERRLOG_EN
    logic [11:0] err_addr_q;
    logic [1:0]  err_cause_q;

    // Remember offset and cause of the access being answered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr_q  <= '0;
            err_cause_q <= MMIO_ERR_NONE;
        end else begin
            if (accept) begin
                err_addr_q <= up_addr;
            end
            if (accept && !mapped) begin
                err_cause_q <= MMIO_ERR_UNMAPPED;
            end else if (timeout_hit) begin
                err_cause_q <= p_wen ? MMIO_ERR_TIMEOUT_WR : MMIO_ERR_TIMEOUT;
            end
        end
    end

    // Error log: first error since clear, plus a saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_log_addr  <= '0;
            err_log_cause <= MMIO_ERR_NONE;
            err_log_cnt   <= '0;
        end else if ((state == MMIO_ST_RESP) && up_err) begin
            if (err_clr || (err_log_cnt == 8'd0)) begin
                err_log_addr  <= err_addr_q;
                err_log_cause <= err_cause_q;
                err_log_cnt   <= 8'd1;
            end else begin
                err_log_cnt <= mmio_sat_inc8(err_log_cnt);
            end
        end else if (err_clr) begin
            err_log_addr  <= '0;
            err_log_cause <= MMIO_ERR_NONE;
            err_log_cnt   <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_mp64_mmio_ctrl.sv
// Directed self-checking bench for mp64_mmio_ctrl (NUM_PERIPH=8, TIMEOUT_CYCLES=4).
module tb_mp64_mmio_ctrl;

    localparam int unsigned NP = 8;

    logic           clk;
    logic           rst_n;
    logic           up_req;
    logic [11:0]    up_addr;
    logic [63:0]    up_wdata;
    logic           up_wen;
    logic [1:0]     up_size;
    logic [63:0]    up_rdata;
    logic           up_ack;
    logic           up_err;
    logic [NP-1:0]  p_req;
    logic [7:0]     p_addr;
    logic [63:0]    p_wdata;
    logic           p_wen;
    logic [1:0]     p_size;
    logic [NP*64-1:0] p_rdata;
    logic [NP-1:0]  p_ack;
    logic           err_irq;
    logic           err_clr;
`ifdef MP64_MMIO_ERRLOG_EN
    logic [11:0]    err_log_addr;
    logic [1:0]     err_log_cause;
    logic [7:0]     err_log_cnt;
`endif

    int total;
    int bad;

    mp64_mmio_ctrl #(
        .NUM_PERIPH     (NP),
        .TIMEOUT_CYCLES (4),
        .ERR_RDATA      (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_req   (up_req),
        .up_addr  (up_addr),
        .up_wdata (up_wdata),
        .up_wen   (up_wen),
        .up_size  (up_size),
        .up_rdata (up_rdata),
        .up_ack   (up_ack),
        .up_err   (up_err),
        .p_req    (p_req),
        .p_addr   (p_addr),
        .p_wdata  (p_wdata),
        .p_wen    (p_wen),
        .p_size   (p_size),
        .p_rdata  (p_rdata),
        .p_ack    (p_ack),
        .err_irq  (err_irq),
        .err_clr  (err_clr)
`ifdef MP64_MMIO_ERRLOG_EN
        ,
        .err_log_addr  (err_log_addr),
        .err_log_cause (err_log_cause),
        .err_log_cnt   (err_log_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [11:0] a, input logic [63:0] wd, input logic we);
        up_req   = 1'b1;
        up_addr  = a;
        up_wdata = wd;
        up_wen   = we;
    endtask

    // Requester drops req after the ack; wait through GAP back to IDLE
    task automatic finish_access();
        up_req = 1'b0;
        p_ack  = '0;
        tick();
        check("gap_ack_low", {63'd0, up_ack}, 64'd0);
        tick();
    endtask

    int hi_cnt;
    int guard;

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        up_req   = 1'b0;
        up_addr  = '0;
        up_wdata = '0;
        up_wen   = 1'b0;
        up_size  = 2'd0;
        p_rdata  = '0;
        p_ack    = '0;
        err_clr  = 1'b0;
        #12;
        check("rst_up_ack", {63'd0, up_ack}, 64'd0);
        check("rst_up_rdata", up_rdata, 64'd0);
        check("rst_p_req", {56'd0, p_req}, 64'd0);
        check("rst_err_irq", {63'd0, err_irq}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Read slot 0: ack during cycle 3, up_ack in cycle 4
        p_rdata[0*64 +: 64] = 64'h41;
        start(12'h010, 64'd0, 1'b0);
        tick();
        check("rd_p_req", {56'd0, p_req}, 64'h01);
        check("rd_p_addr", {56'd0, p_addr}, 64'h10);
        check("rd_p_wen", {63'd0, p_wen}, 64'd0);
        tick();
        tick();
        check("rd_no_early_ack", {63'd0, up_ack}, 64'd0);
        p_ack[0] = 1'b1;
        tick();
        check("rd_ack", {63'd0, up_ack}, 64'd1);
        check("rd_err", {63'd0, up_err}, 64'd0);
        check("rd_rdata", up_rdata, 64'h41);
        check("rd_p_req_drop", {56'd0, p_req}, 64'd0);
        finish_access();

        // Write slot 2: ack in the same cycle p_req rises
        up_size = 2'b11;
        start(12'h208, 64'hCAFE, 1'b1);
        tick();
        check("wr_p_req", {56'd0, p_req}, 64'h04);
        check("wr_p_wen", {63'd0, p_wen}, 64'd1);
        check("wr_p_wdata", p_wdata, 64'hCAFE);
        check("wr_p_size", {62'd0, p_size}, 64'd3);
        check("wr_p_addr", {56'd0, p_addr}, 64'h08);
        p_ack[2] = 1'b1;
        tick();
        check("wr_ack", {63'd0, up_ack}, 64'd1);
        check("wr_err", {63'd0, up_err}, 64'd0);
        finish_access();
        up_size = 2'd0;

        // Unmapped slot 15: immediate error response, no slot touched
        start(12'hF00, 64'h1234, 1'b1);
        tick();
        check("um_ack", {63'd0, up_ack}, 64'd1);
        check("um_err", {63'd0, up_err}, 64'd1);
        check("um_rdata", up_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("um_p_req", {56'd0, p_req}, 64'd0);
        up_req = 1'b0;
        tick();
        check("um_irq", {63'd0, err_irq}, 64'd1);
        check("um_ack_low", {63'd0, up_ack}, 64'd0);
`ifdef MP64_MMIO_ERRLOG_EN
        check("um_log_cause", {62'd0, err_log_cause}, 64'd1);
        check("um_log_addr", {52'd0, err_log_addr}, 64'hF00);
`endif
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_irq", {63'd0, err_irq}, 64'd0);

        // Timeout on slot 3: p_req high TIMEOUT+1 = 5 cycles
        start(12'h320, 64'd0, 1'b0);
        tick();
        hi_cnt = 0;
        guard  = 0;
        while (p_req[3] && guard < 20) begin
            hi_cnt++;
            guard++;
            tick();
        end
        check("to_p_req_cycles", 64'(hi_cnt), 64'd5);
        check("to_ack", {63'd0, up_ack}, 64'd1);
        check("to_err", {63'd0, up_err}, 64'd1);
        check("to_rdata", up_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        finish_access();
        check("to_irq", {63'd0, err_irq}, 64'd1);
`ifdef MP64_MMIO_ERRLOG_EN
        check("to_log_cause", {62'd0, err_log_cause}, 64'd2);
        check("to_log_cnt", {56'd0, err_log_cnt}, 64'd1);
`endif

        // Ack in the expiry cycle (5th p_req cycle) must complete ok
        p_rdata[3*64 +: 64] = 64'h55;
        start(12'h300, 64'd0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("exp_p_req", {56'd0, p_req}, 64'h08);
        p_ack[3] = 1'b1;
        tick();
        check("exp_ack", {63'd0, up_ack}, 64'd1);
        check("exp_err", {63'd0, up_err}, 64'd0);
        check("exp_rdata", up_rdata, 64'h55);
        finish_access();

        // Stray ack on slot 1 during an access to slot 4
        p_rdata[1*64 +: 64] = 64'h11;
        p_rdata[4*64 +: 64] = 64'h44;
        start(12'h400, 64'd0, 1'b0);
        tick();
        p_ack[1] = 1'b1;
        tick();
        tick();
        check("stray_no_ack", {63'd0, up_ack}, 64'd0);
        check("stray_p_req", {56'd0, p_req}, 64'h10);
        p_ack[1] = 1'b0;
        p_ack[4] = 1'b1;
        tick();
        check("stray_ack", {63'd0, up_ack}, 64'd1);
        check("stray_rdata", up_rdata, 64'h44);
        check("stray_err", {63'd0, up_err}, 64'd0);
        finish_access();

        // err_clr coinciding with a new error: set wins
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr2_irq", {63'd0, err_irq}, 64'd0);
        start(12'hA00, 64'd0, 1'b0);
        tick();
        check("co_ack", {63'd0, up_ack}, 64'd1);
        err_clr = 1'b1;
        up_req  = 1'b0;
        tick();
        err_clr = 1'b0;
        check("co_irq", {63'd0, err_irq}, 64'd1);
`ifdef MP64_MMIO_ERRLOG_EN
        check("co_log_cnt", {56'd0, err_log_cnt}, 64'd1);
        check("co_log_cause", {62'd0, err_log_cause}, 64'd1);
`endif
        tick();

        // Asynchronous reset in the middle of an access
        start(12'h500, 64'd0, 1'b0);
        tick();
        tick();
        check("rr_p_req", {56'd0, p_req}, 64'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_p_req_drop", {56'd0, p_req}, 64'd0);
        check("rr_ack", {63'd0, up_ack}, 64'd0);
        check("rr_irq", {63'd0, err_irq}, 64'd0);
        up_req = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("rr_no_ack", {63'd0, up_ack}, 64'd0);
        p_rdata[5*64 +: 64] = 64'h5A5A;
        start(12'h5F0, 64'd0, 1'b0);
        tick();
        check("rr2_p_req", {56'd0, p_req}, 64'h20);
        check("rr2_p_addr", {56'd0, p_addr}, 64'hF0);
        p_ack[5] = 1'b1;
        tick();
        check("rr2_ack", {63'd0, up_ack}, 64'd1);
        check("rr2_rdata", up_rdata, 64'h5A5A);
        check("rr2_err", {63'd0, up_err}, 64'd0);
        finish_access();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
